// File: rtl/cache_pkg.sv
// Shared definitions for the cache block-fill controller: state encoding,
// default block geometry and the width helpers derived from it.
package cache_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_t;

  localparam int WORDS_PER_BLOCK_DEF = 8;
  localparam int OFF_W               = $clog2(WORDS_PER_BLOCK_DEF);
  localparam int BYTE_OFF_W          = OFF_W + 1;

  // Word-offset width for an arbitrary block size.
  function automatic int off_width(input int words);
    return $clog2(words);
  endfunction

endpackage

// File: rtl/fill_counter.sv
// Small up-counter used for the issue and receive word counts of a block fill;
// synchronous clear wins over enable.
module fill_counter
  import cache_pkg::*;
#(
  parameter int WIDTH = OFF_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/cache_fill_fsm.sv
// Block-fill controller: on a miss, streams one memory read per cycle for the
// whole block and writes each returned word; optional CACHE_FILL_CRITICAL_WORD_FIRST_EN.
module cache_fill_fsm
  import cache_pkg::*;
#(
  parameter int WORDS_PER_BLOCK = WORDS_PER_BLOCK_DEF,
  parameter int MEM_LATENCY     = 4,
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic              memory_data_valid,
  input  logic [DATA_W-1:0] memory_data,
  output logic              fsm_busy,
  output logic              mem_enable,
  output logic [ADDR_W-1:0] memory_address,
  output logic              write_data_array,
  output logic [ADDR_W-1:0] fill_address,
  output logic [DATA_W-1:0] fill_data,
  output logic              write_tag_array
);

  localparam int OW    = off_width(WORDS_PER_BLOCK);
  localparam int BOW   = OW + 1;
  localparam int CNT_W = OW + 1;

  localparam logic [CNT_W-1:0]  NUM_WORDS  = CNT_W'(WORDS_PER_BLOCK);
  localparam logic [CNT_W-1:0]  LAST_IDX   = CNT_W'(WORDS_PER_BLOCK - 1);
  localparam logic [ADDR_W-1:0] BLOCK_MASK = ~ADDR_W'((1 << BOW) - 1);

  // The FSM only counts returns, so latency never shapes the logic; it is
  // still checked so a nonsensical configuration is caught at elaboration.
  if ((WORDS_PER_BLOCK < 2) || (WORDS_PER_BLOCK > 16) ||
      ((WORDS_PER_BLOCK & (WORDS_PER_BLOCK - 1)) != 0) ||
      (MEM_LATENCY < 1) || (DATA_W < 1) || (ADDR_W <= BOW)) begin : g_bad_cfg
    $error("cache_fill_fsm: unsupported parameter combination");
  end

  fill_state_t       state;
  logic [ADDR_W-1:0] base;
  logic [OW-1:0]     start_off;
  logic [OW-1:0]     miss_off;
  logic [CNT_W-1:0]  iss_cnt;
  logic [CNT_W-1:0]  rcv_cnt;
  logic              issuing;
  logic              returning;
  logic              last_return;

  // Offset math is OW bits wide, so the word index wraps inside the block and
  // can never carry into the tag bits of the latched base.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] blk,
                                                  input logic [OW-1:0]     first,
                                                  input logic [OW-1:0]     idx);
    logic [OW-1:0] off;
    off = first + idx;
    return blk | ADDR_W'({off, 1'b0});
  endfunction

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
  assign miss_off = miss_address[BOW-1:1];
`else
  assign miss_off = '0;
`endif

  assign issuing     = (state == FILL) && (iss_cnt < NUM_WORDS);
  assign returning   = (state == FILL) && memory_data_valid;
  assign last_return = returning && (rcv_cnt == LAST_IDX);

  // Stall is raised in the miss cycle itself, before the FSM has moved.
  assign fsm_busy         = (state == FILL) || miss_detected;
  assign mem_enable       = issuing;
  assign memory_address   = issuing ? word_addr(base, start_off, iss_cnt[OW-1:0]) : '0;
  assign write_data_array = returning;
  assign fill_address     = returning ? word_addr(base, start_off, rcv_cnt[OW-1:0]) : '0;
  assign fill_data        = memory_data;
  assign write_tag_array  = last_return;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      base      <= '0;
      start_off <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss_detected) begin
            base      <= miss_address & BLOCK_MASK;
            start_off <= miss_off;
            state     <= FILL;
          end
        end
        FILL: begin
          if (last_return) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  fill_counter #(.WIDTH(CNT_W)) u_iss_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (issuing),
    .clr   (last_return),
    .count (iss_cnt)
  );

  fill_counter #(.WIDTH(CNT_W)) u_rcv_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (returning),
    .clr   (last_return),
    .count (rcv_cnt)
  );

endmodule
